dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache with its controller FSM.
- Sits in the memory-access stage between the pipeline's data-memory port (ALU result address, store data, MemRW) and a word-wide backing memory.
- Stalls the pipeline on a miss and sequences line eviction and refill over a req/ack handshake.

Parameters:
- LINES, 16, number of cache lines; power of two.
- WPL, 4, 32-bit words per line; power of two.
- IDX_W, 4, index width; must equal log2(LINES).
- OFF_W, 2, word-offset width; must equal log2(WPL).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  memory-stage access valid (load or store).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  freeze pipeline.
- mem_req  out  1  backing-memory transfer request.
- mem_we  out  1  1 = write word, 0 = read word.
- mem_addr  out  32  word-aligned backing address.
- mem_wdata  out  32  eviction data.
- mem_rdata  in  32  refill data; valid when mem_ack = 1.
- mem_ack  in  1  transfer complete this cycle.

Behaviour:
- Address split: offset = addr[OFF_W+1:2], index = addr[IDX_W+OFF_W+1:OFF_W+2], tag = remaining upper bits (24 bits at defaults).
- Per line storage: valid, dirty, tag, WPL data words. No reset on the data array.
- Hit = cpu_req & valid[index] & (tag match) & state==IDLE.
- Hit timing:
  - cpu_rdata is combinational from the array in the same cycle; cpu_stall = 0.
  - A store hit writes the word at posedge and sets dirty.
  - Back-to-back hits run at one per cycle.
- Miss: cpu_stall = 1 combinationally in the same cycle. cpu_stall = cpu_req & ~hit, OR state != IDLE.
- The CPU holds cpu_req, cpu_we, cpu_addr and cpu_wdata stable while stalled.
- FSM states:
  - IDLE: on a miss, go to EVICT if the victim is valid & dirty, else go to FILL. Word counter cnt is set to 0.
  - EVICT: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, cnt, 2'b00}, mem_wdata = line word cnt. On mem_ack, cnt increments. On the ack with cnt == WPL-1, go to FILL with cnt = 0.
  - FILL: mem_req = 1, mem_we = 0, mem_addr = {req tag, index, cnt, 2'b00}. On mem_ack, write mem_rdata to word cnt and increment cnt. On the last ack, set tag, valid = 1, dirty = 0, and go to IDLE.
- After FILL returns to IDLE, the held request hits the next cycle; a store completes then and sets dirty.
- Miss penalty with zero-wait ack: 4 cycles for a clean miss, 8 for a dirty miss, plus 1 hit cycle.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable until the cycle mem_ack is sampled high.
  - mem_req may stay high across consecutive words, with a new address on the next cycle.
  - mem_ack while mem_req = 0 is ignored.
  - Unbounded wait states are allowed; no timeout.
- Outputs in IDLE: mem_req = 0; mem_we, mem_addr and mem_wdata = 0.
- cpu_req dropping mid-miss: the current EVICT/FILL still completes, then the FSM returns to IDLE.
- Reset values:
  - rst_n low asynchronously clears all valid and dirty bits, sets state = IDLE and cnt = 0.
  - mem_req, mem_we, mem_addr, mem_wdata and cpu_rdata are forced to 0.
  - cpu_stall follows cpu_req, since all lines are invalid.
  - Reset mid-EVICT/FILL aborts the transfer immediately; the partial line is discarded.
- cnt wraps naturally at WPL. There are no other counters.

Test Plan:
- Cold load 0x0000_0100 after reset:
  - cpu_stall = 1 for 4 cycles (ack every cycle).
  - mem_addr sequence is 0x100, 0x104, 0x108, 0x10C, all with mem_we = 0.
  - Then a hit with cpu_rdata = the word at 0x100.
- Store 0xDEAD_BEEF to 0x104 after the fill: no stall; a following load of 0x104 returns 0xDEAD_BEEF with no mem_req.
- Load 0x0000_0200 (same index 0, tag 2) with line 0 dirty:
  - 4 writes to 0x100–0x10C; the word at 0x104 carries 0xDEAD_BEEF.
  - Then 4 reads from 0x200–0x20C; stall held for all 8 transfers.
- Refill with mem_ack delayed 3 cycles per word:
  - mem_addr is held for each wait; cpu_stall lasts 16 cycles.
  - Final data is correct.
- rst_n pulsed low during FILL word 2:
  - mem_req drops at once.
  - After release, a load to that address misses again and refills fully.
- Alternating hits to 0x100 and 0x104 for 10 cycles: cpu_stall = 0 throughout; mem_req = 0 throughout.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl_if
// Description : Bundles the pipeline-side access port and the word-wide
//               backing-memory req/ack port of the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_ctrl_if;
  // Pipeline memory-stage side
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  // Backing-memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Environment view: drives CPU requests and memory responses
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  // Cache view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate data cache with its
//               miss-handling FSM (evict dirty victim, then refill line).
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WPL   = 4,
  parameter int IDX_W = 4,
  parameter int OFF_W = 2
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  dcache_ctrl_if.slave  bus
);

  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] C_OFF_ZERO = '0;
  localparam logic [OFF_W-1:0] C_OFF_LAST = OFF_W'(WPL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVICT = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [OFF_W-1:0]  r_cnt;
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [LINES*WPL];
  // Index and tag of the missing access, captured so the refill does not
  // depend on the CPU keeping its request up.
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_req_tag;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_miss;
  logic              w_ack;
  logic              w_last;
  logic [OFF_W-1:0]  w_cnt_nxt;
  logic              w_unused;

  assign w_off     = bus.cpu_addr[OFF_W+1:2];
  assign w_idx     = bus.cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign w_tag     = bus.cpu_addr[31:IDX_W+OFF_W+2];
  assign w_unused  = ^bus.cpu_addr[1:0];

  assign w_hit     = bus.cpu_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag) &
                     (r_state == S_IDLE);
  assign w_miss    = bus.cpu_req & ~w_hit & (r_state == S_IDLE);
  // An ack only counts while a transfer is actually being requested.
  assign w_ack     = r_mem_req & bus.mem_ack;
  assign w_last    = (r_cnt == C_OFF_LAST);
  assign w_cnt_nxt = r_cnt + OFF_W'(1);

  assign bus.cpu_rdata = w_hit ? r_data[{w_idx, w_off}] : 32'd0;
  assign bus.cpu_stall = (bus.cpu_req & ~w_hit) | (r_state != S_IDLE);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  // Data words and tags: store hits and refill words; no reset needed since
  // the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_hit && bus.cpu_we) begin
      r_data[{w_idx, w_off}] <= bus.cpu_wdata;
    end
    if ((r_state == S_FILL) && w_ack) begin
      r_data[{r_idx, r_cnt}] <= bus.mem_rdata;
      if (w_last) begin
        r_tag[r_idx] <= r_req_tag;
      end
    end
  end

  // Miss FSM with registered memory-port outputs and line status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_idx       <= '0;
      r_req_tag   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_idx     <= w_idx;
            r_req_tag <= w_tag;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state     <= S_EVICT;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx, C_OFF_ZERO, 2'b00};
              r_mem_wdata <= r_data[{w_idx, C_OFF_ZERO}];
            end else begin
              r_state     <= S_FILL;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= {w_tag, w_idx, C_OFF_ZERO, 2'b00};
              r_mem_wdata <= '0;
            end
          end else if (w_hit && bus.cpu_we) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_EVICT: begin
          if (w_ack) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              // Victim fully written back; switch to reading the new line.
              r_state     <= S_FILL;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= {r_req_tag, r_idx, C_OFF_ZERO, 2'b00};
              r_mem_wdata <= '0;
            end else begin
              r_mem_addr  <= {r_tag[r_idx], r_idx, w_cnt_nxt, 2'b00};
              r_mem_wdata <= r_data[{r_idx, w_cnt_nxt}];
            end
          end
        end
        S_FILL: begin
          if (w_ack) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_state        <= S_IDLE;
              r_valid[r_idx] <= 1'b1;
              r_dirty[r_idx] <= 1'b0;
              r_mem_req      <= 1'b0;
              r_mem_addr     <= '0;
            end else begin
              r_mem_addr <= {r_req_tag, r_idx, w_cnt_nxt, 2'b00};
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Directed bench for dcache_ctrl with a word-wide backing
//               memory model (programmable ack delay) and transfer log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_busy;
    int          exp_xfers;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   ack_delay;
  int   wcnt;
  int   hold_err;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;
  logic [31:0] mem [logic [31:0]];
  xfer_t       xlog [$];
  vec_t        vecs [11];

  dcache_ctrl_if bus ();

  dcache_ctrl #(.LINES(16), .WPL(4), .IDX_W(4), .OFF_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background contents of never-written memory words.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  // Backing memory: decides ack for the coming edge, logs accepted transfers
  // and watches that the request stays put while waiting.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (prev_req && !prev_ack && (bus.mem_addr != prev_addr)) hold_err++;
      if (wcnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else            bus.mem_rdata = mem_rd(bus.mem_addr);
        xlog.push_back('{we: bus.mem_we, addr: bus.mem_addr,
                         data: (bus.mem_we ? bus.mem_wdata : bus.mem_rdata)});
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'd0;
      wcnt = 0;
    end
    prev_req  = bus.mem_req;
    prev_ack  = bus.mem_ack;
    prev_addr = bus.mem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One CPU access held until it completes; busy = stalled cycles after the
  // initial miss cycle (i.e. cycles spent in EVICT/FILL).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int busy);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    while (bus.cpu_stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (bus.cpu_stall) begin
      n_checks++;
      n_errors++;
      $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, n);
    end
    rdata = bus.cpu_rdata;
    busy  = (n > 0) ? n - 1 : 0;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          busy;
    int          sz0;
    int          n;

    n_checks = 0; n_errors = 0; ack_delay = 0; wcnt = 0; hold_err = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;

    //            we    addr          wdata         exp_rdata    busy xfers
    vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h5B5A_0100, 4, 4};
    vecs[1]  = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0, 0};
    vecs[2]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 0, 0};
    vecs[3]  = '{1'b0, 32'h0000_010C, 32'h0,        32'h5B56_010C, 0, 0};
    vecs[4]  = '{1'b0, 32'h0000_0200, 32'h0,        32'h585A_0200, 8, 8};
    vecs[5]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 4, 4};
    vecs[6]  = '{1'b0, 32'h0000_020C, 32'h0,        32'h5856_020C, 4, 4};
    vecs[7]  = '{1'b1, 32'h0000_03F0, 32'h1234_5678, 32'h0,        4, 4};
    vecs[8]  = '{1'b0, 32'h0000_03F0, 32'h0,        32'h1234_5678, 0, 0};
    vecs[9]  = '{1'b0, 32'h0000_13F0, 32'h0,        32'h49AA_13F0, 8, 8};
    vecs[10] = '{1'b0, 32'h0000_03F0, 32'h0,        32'h1234_5678, 4, 4};

    // Reset state
    #2;
    chk("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we},  32'd0);
    chk("rst_mem_addr",  bus.mem_addr,         32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,        32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata,        32'd0);
    chk("rst_stall_idle", {31'd0, bus.cpu_stall}, 32'd0);
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h100;
    #1;
    chk("rst_stall_req", {31'd0, bus.cpu_stall}, 32'd1);
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven access sequence
    foreach (vecs[i]) begin
      sz0 = xlog.size();
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, busy);
      if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_xfers", i), xlog.size() - sz0, vecs[i].exp_xfers);
    end

    // Dirty eviction: line 0 holds tag 2 (clean); dirty it, then miss on 0x100
    do_access(1'b1, 32'h204, 32'hDEAD_BEEF, rd, busy);
    chk("ev_store_busy", busy, 0);
    xlog.delete();
    do_access(1'b0, 32'h100, 32'h0, rd, busy);
    chk("ev_busy", busy, 8);
    chk("ev_rdata", rd, 32'h5B5A_0100);
    chk("ev_nxfers", xlog.size(), 8);
    if (xlog.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ev_w%0d_we", i), {31'd0, xlog[i].we}, 32'd1);
        chk($sformatf("ev_w%0d_addr", i), xlog[i].addr, 32'h200 + 32'(4 * i));
        chk($sformatf("ev_w%0d_data", i), xlog[i].data,
            (i == 1) ? 32'hDEAD_BEEF : pat(32'h200 + 32'(4 * i)));
        chk($sformatf("ev_r%0d_we", i), {31'd0, xlog[i+4].we}, 32'd0);
        chk($sformatf("ev_r%0d_addr", i), xlog[i+4].addr, 32'h100 + 32'(4 * i));
      end
    end

    // Refill with three wait cycles before every ack
    ack_delay = 3;
    hold_err  = 0;
    do_access(1'b0, 32'h500, 32'h0, rd, busy);
    chk("slow_busy", busy, 16);
    chk("slow_rdata", rd, 32'h5F5A_0500);
    chk("slow_hold", hold_err, 0);
    ack_delay = 0;
    do_access(1'b0, 32'h50C, 32'h0, rd, busy);
    chk("slow_word3", rd, pat(32'h50C));

    // Reset while the third refill word is on the bus
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h600;
    n = 0;
    @(negedge clk);
    while (!(bus.mem_req && bus.mem_addr == 32'h608) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("rstfill_reached", bus.mem_addr, 32'h608);
    #1 rst_n = 1'b0;
    #1;
    chk("rstfill_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rstfill_mem_addr", bus.mem_addr, 32'd0);
    chk("rstfill_stall", {31'd0, bus.cpu_stall}, 32'd1);
    bus.cpu_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    xlog.delete();
    do_access(1'b0, 32'h600, 32'h0, rd, busy);
    chk("rstfill_busy", busy, 4);
    chk("rstfill_rdata", rd, 32'h5C5A_0600);
    chk("rstfill_nxfers", xlog.size(), 4);
    if (xlog.size() == 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("rstfill_r%0d_addr", i), xlog[i].addr, 32'h600 + 32'(4 * i));
    end

    // Back-to-back alternating hits within one line
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.cpu_addr = (i % 2 == 0) ? 32'h600 : 32'h604;
      @(negedge clk);
      chk($sformatf("alt%0d_stall", i), {31'd0, bus.cpu_stall}, 32'd0);
      chk($sformatf("alt%0d_mem_req", i), {31'd0, bus.mem_req}, 32'd0);
      chk($sformatf("alt%0d_rdata", i), bus.cpu_rdata,
          (i % 2 == 0) ? 32'h5C5A_0600 : 32'h5C5E_0604);
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound for the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
